// File: rtl/soml_frame_scheduler.sv
// soml_frame_scheduler
// Collects H and Y sample words into a two-bank ping-pong frame store and
// sequences one frame at a time into the decoder: start pulse, H burst,
// Y burst, then wait for the decoder result. One bank can fill while the
// other is being decoded.
// Optional watchdog: define SCHED_TIMEOUT_EN to abandon a frame after
// TIMEOUT cycles in WAIT. Without it, WAIT exits only on dec_done and
// timeout_err is tied low.
//
// Handshake: every *_valid strobe (in_h_valid, in_y_valid, dec_h_valid,
// dec_y_valid, result_valid) qualifies its data for exactly the cycle it
// is high; there is no back-pressure, so a word offered when it cannot be
// stored is dropped and flagged via the sticky overflow output.
module soml_frame_scheduler #(
  parameter int H_WORDS = 4,
  parameter int Y_WORDS = 4,
  parameter int TIMEOUT = 1023,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         sys_rst,
  input  logic [W-1:0] in_h_r,
  input  logic [W-1:0] in_h_i,
  input  logic         in_h_valid,
  input  logic [W-1:0] in_y_r,
  input  logic [W-1:0] in_y_i,
  input  logic         in_y_valid,
  output logic         dec_start,
  output logic [W-1:0] dec_h_r,
  output logic [W-1:0] dec_h_i,
  output logic         dec_h_valid,
  output logic [W-1:0] dec_y_r,
  output logic [W-1:0] dec_y_i,
  output logic         dec_y_valid,
  input  logic         dec_done,
  input  logic [11:0]  dec_sym,
  output logic         result_valid,
  output logic [11:0]  result_sym,
  output logic [15:0]  frame_count,
  output logic         overflow,
  output logic         timeout_err,
  output logic         busy
);

  localparam int HC_W  = $clog2(H_WORDS + 1);
  localparam int YC_W  = $clog2(Y_WORDS + 1);
  localparam int HI_W  = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int YI_W  = (Y_WORDS > 1) ? $clog2(Y_WORDS) : 1;
  localparam int IDX_W = (HI_W > YI_W) ? HI_W : YI_W;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SEND_H, S_SEND_Y, S_WAIT, S_RELEASE
  } state_t;

  // Frame store: [bank][word]
  logic [W-1:0] h_r_mem_q [2][H_WORDS];
  logic [W-1:0] h_i_mem_q [2][H_WORDS];
  logic [W-1:0] y_r_mem_q [2][Y_WORDS];
  logic [W-1:0] y_i_mem_q [2][Y_WORDS];

  // Fill side state
  logic [HC_W-1:0] h_cnt_q, h_cnt_d;
  logic [YC_W-1:0] y_cnt_q, y_cnt_d;
  logic            fill_ptr_q, fill_ptr_d;
  logic [1:0]      full_q, full_d;
  logic            overflow_q, overflow_d;
  logic            release_w, fill_full, h_acc, y_acc, complete;

  // Dispatch side state
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic             disp_ptr_q, disp_ptr_d;
  logic             dec_start_q, dec_start_d;
  logic             dec_h_valid_q, dec_h_valid_d;
  logic [W-1:0]     dec_h_r_q, dec_h_r_d, dec_h_i_q, dec_h_i_d;
  logic             dec_y_valid_q, dec_y_valid_d;
  logic [W-1:0]     dec_y_r_q, dec_y_r_d, dec_y_i_q, dec_y_i_d;
  logic             result_valid_q, result_valid_d;
  logic [11:0]      result_sym_q, result_sym_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             wd_expire;

  // Fill bookkeeping; a release in this cycle frees its bank before the write is judged
  always_comb begin
    release_w  = (state_q == S_RELEASE);
    fill_full  = full_q[fill_ptr_q] && !(release_w && (disp_ptr_q == fill_ptr_q));
    h_acc      = in_h_valid && !fill_full && (h_cnt_q != HC_W'(H_WORDS));
    y_acc      = in_y_valid && !fill_full && (y_cnt_q != YC_W'(Y_WORDS));
    h_cnt_d    = h_cnt_q;
    y_cnt_d    = y_cnt_q;
    if (h_acc) h_cnt_d = h_cnt_q + 1'b1;
    if (y_acc) y_cnt_d = y_cnt_q + 1'b1;
    complete   = (h_cnt_d == HC_W'(H_WORDS)) && (y_cnt_d == YC_W'(Y_WORDS));
    fill_ptr_d = fill_ptr_q;
    full_d     = full_q;
    if (release_w) full_d[disp_ptr_q] = 1'b0;
    if (complete) begin
      full_d[fill_ptr_q] = 1'b1;
      h_cnt_d            = '0;
      y_cnt_d            = '0;
      fill_ptr_d         = ~fill_ptr_q;
    end
    overflow_d = overflow_q | (in_h_valid && !h_acc) | (in_y_valid && !y_acc);
  end

  // Sample writes into the bank currently being filled
  always_ff @(posedge clk) begin
    if (h_acc) begin
      h_r_mem_q[fill_ptr_q][h_cnt_q[HI_W-1:0]] <= in_h_r;
      h_i_mem_q[fill_ptr_q][h_cnt_q[HI_W-1:0]] <= in_h_i;
    end
    if (y_acc) begin
      y_r_mem_q[fill_ptr_q][y_cnt_q[YI_W-1:0]] <= in_y_r;
      y_i_mem_q[fill_ptr_q][y_cnt_q[YI_W-1:0]] <= in_y_i;
    end
  end

  // Dispatch FSM next state and next registered outputs
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    idx_nxt        = idx_q + 1'b1;
    disp_ptr_d     = disp_ptr_q;
    dec_start_d    = 1'b0;
    dec_h_valid_d  = 1'b0;
    dec_h_r_d      = '0;
    dec_h_i_d      = '0;
    dec_y_valid_d  = 1'b0;
    dec_y_r_d      = '0;
    dec_y_i_d      = '0;
    result_valid_d = 1'b0;
    result_sym_d   = result_sym_q;
    frame_count_d  = frame_count_q;
    case (state_q)
      S_IDLE: begin
        if (full_q[disp_ptr_q]) begin
          state_d     = S_START;
          dec_start_d = 1'b1;
        end
      end
      S_START: begin
        state_d       = S_SEND_H;
        idx_d         = '0;
        dec_h_valid_d = 1'b1;
        dec_h_r_d     = h_r_mem_q[disp_ptr_q][0];
        dec_h_i_d     = h_i_mem_q[disp_ptr_q][0];
      end
      S_SEND_H: begin
        if (idx_q == IDX_W'(H_WORDS - 1)) begin
          state_d       = S_SEND_Y;
          idx_d         = '0;
          dec_y_valid_d = 1'b1;
          dec_y_r_d     = y_r_mem_q[disp_ptr_q][0];
          dec_y_i_d     = y_i_mem_q[disp_ptr_q][0];
        end else begin
          idx_d         = idx_nxt;
          dec_h_valid_d = 1'b1;
          dec_h_r_d     = h_r_mem_q[disp_ptr_q][idx_nxt[HI_W-1:0]];
          dec_h_i_d     = h_i_mem_q[disp_ptr_q][idx_nxt[HI_W-1:0]];
        end
      end
      S_SEND_Y: begin
        if (idx_q == IDX_W'(Y_WORDS - 1)) begin
          state_d = S_WAIT;
          idx_d   = '0;
        end else begin
          idx_d         = idx_nxt;
          dec_y_valid_d = 1'b1;
          dec_y_r_d     = y_r_mem_q[disp_ptr_q][idx_nxt[YI_W-1:0]];
          dec_y_i_d     = y_i_mem_q[disp_ptr_q][idx_nxt[YI_W-1:0]];
        end
      end
      S_WAIT: begin
        // dec_done beats a simultaneous watchdog expiry
        if (dec_done) begin
          result_sym_d   = dec_sym;
          result_valid_d = 1'b1;
          frame_count_d  = frame_count_q + 16'd1;
          state_d        = S_RELEASE;
        end else if (wd_expire) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        disp_ptr_d = ~disp_ptr_q;
        // Go straight to START when the other bank is already waiting
        if (full_q[~disp_ptr_q]) begin
          state_d     = S_START;
          dec_start_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fill and dispatch registers with synchronous reset
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      h_cnt_q        <= '0;
      y_cnt_q        <= '0;
      fill_ptr_q     <= 1'b0;
      full_q         <= '0;
      overflow_q     <= 1'b0;
      state_q        <= S_IDLE;
      idx_q          <= '0;
      disp_ptr_q     <= 1'b0;
      dec_start_q    <= 1'b0;
      dec_h_valid_q  <= 1'b0;
      dec_h_r_q      <= '0;
      dec_h_i_q      <= '0;
      dec_y_valid_q  <= 1'b0;
      dec_y_r_q      <= '0;
      dec_y_i_q      <= '0;
      result_valid_q <= 1'b0;
      result_sym_q   <= '0;
      frame_count_q  <= '0;
    end else begin
      h_cnt_q        <= h_cnt_d;
      y_cnt_q        <= y_cnt_d;
      fill_ptr_q     <= fill_ptr_d;
      full_q         <= full_d;
      overflow_q     <= overflow_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      disp_ptr_q     <= disp_ptr_d;
      dec_start_q    <= dec_start_d;
      dec_h_valid_q  <= dec_h_valid_d;
      dec_h_r_q      <= dec_h_r_d;
      dec_h_i_q      <= dec_h_i_d;
      dec_y_valid_q  <= dec_y_valid_d;
      dec_y_r_q      <= dec_y_r_d;
      dec_y_i_q      <= dec_y_i_d;
      result_valid_q <= result_valid_d;
      result_sym_q   <= result_sym_d;
      frame_count_q  <= frame_count_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_err_q, timeout_err_d;

  assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog counts WAIT cycles and is held at zero everywhere else
  always_comb begin
    wd_d          = '0;
    if (state_q == S_WAIT) wd_d = wd_q + 1'b1;
    timeout_err_d = timeout_err_q | ((state_q == S_WAIT) && !dec_done && wd_expire);
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // No watchdog in this build; TIMEOUT has no effect
  assign wd_expire   = 1'b0 && (TIMEOUT != 0);
  assign timeout_err = 1'b0;
`endif

  assign dec_start    = dec_start_q;
  assign dec_h_valid  = dec_h_valid_q;
  assign dec_h_r      = dec_h_r_q;
  assign dec_h_i      = dec_h_i_q;
  assign dec_y_valid  = dec_y_valid_q;
  assign dec_y_r      = dec_y_r_q;
  assign dec_y_i      = dec_y_i_q;
  assign result_valid = result_valid_q;
  assign result_sym   = result_sym_q;
  assign frame_count  = frame_count_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_soml_frame_scheduler.sv
// Bench for soml_frame_scheduler: directed frame scenarios plus random
// traffic, checked every cycle against a queue/timeline model of frames.
module tb_soml_frame_scheduler;
  localparam int H  = 4;
  localparam int Y  = 4;
  localparam int TO = 16;
  localparam int W  = 32;
`ifdef SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         sys_rst;
  logic [W-1:0] in_h_r, in_h_i, in_y_r, in_y_i;
  logic         in_h_valid, in_y_valid;
  logic         dec_start, dec_h_valid, dec_y_valid;
  logic [W-1:0] dec_h_r, dec_h_i, dec_y_r, dec_y_i;
  logic         dec_done;
  logic [11:0]  dec_sym;
  logic         result_valid;
  logic [11:0]  result_sym;
  logic [15:0]  frame_count;
  logic         overflow, timeout_err, busy;

  soml_frame_scheduler #(.H_WORDS(H), .Y_WORDS(Y), .TIMEOUT(TO), .W(W)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .in_h_r(in_h_r), .in_h_i(in_h_i), .in_h_valid(in_h_valid),
    .in_y_r(in_y_r), .in_y_i(in_y_i), .in_y_valid(in_y_valid),
    .dec_start(dec_start),
    .dec_h_r(dec_h_r), .dec_h_i(dec_h_i), .dec_h_valid(dec_h_valid),
    .dec_y_r(dec_y_r), .dec_y_i(dec_y_i), .dec_y_valid(dec_y_valid),
    .dec_done(dec_done), .dec_sym(dec_sym),
    .result_valid(result_valid), .result_sym(result_sym),
    .frame_count(frame_count), .overflow(overflow),
    .timeout_err(timeout_err), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  // Complete frames waiting or in flight (at most two), oldest first.
  logic [2*W-1:0] q_h[$], q_y[$], part_h[$], part_y[$];
  int             q_ready[$];
  bit             m_act, m_dec, m_got;
  int             m_s, m_w0, m_d;
  logic [11:0]    m_rsym;
  logic [15:0]    m_fc;
  bit             m_ovf, m_terr;
  bit             e_start, e_hv, e_yv, e_rv, e_busy;
  logic [W-1:0]   e_hr, e_hi, e_yr, e_yi;

  // monitor of observed event cycles for literal timing checks
  int mon_start, mon_fh, mon_lh, mon_fy, mon_ly, mon_rv, mon_rv_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q_h.delete(); q_y.delete(); q_ready.delete(); part_h.delete(); part_y.delete();
    m_act = 0; m_dec = 0; m_got = 0; m_rsym = '0; m_fc = '0; m_ovf = 0; m_terr = 0;
  endtask

  // Advance the model over cycle c (inputs of c sampled), producing expectations for c+1.
  task automatic model_step();
    int c, cn, j;
    c = cyc;
    cn = c + 1;
    if (sys_rst) begin
      model_reset();
    end else begin
      if (m_act && !m_dec && c >= m_w0) begin
        if (dec_done) begin
          m_dec = 1; m_got = 1; m_d = c; m_rsym = dec_sym; m_fc = m_fc + 16'd1;
        end else if (TO_EN && c == m_w0 + TO - 1) begin
          m_dec = 1; m_got = 0; m_d = c; m_terr = 1;
        end
      end
      if (m_act && m_dec && c == m_d + 1) begin
        for (int i = 0; i < H; i++) void'(q_h.pop_front());
        for (int i = 0; i < Y; i++) void'(q_y.pop_front());
        void'(q_ready.pop_front());
        m_act = 0;
      end
      if (in_h_valid) begin
        if (q_ready.size() < 2 && part_h.size() < H) part_h.push_back({in_h_r, in_h_i});
        else m_ovf = 1;
      end
      if (in_y_valid) begin
        if (q_ready.size() < 2 && part_y.size() < Y) part_y.push_back({in_y_r, in_y_i});
        else m_ovf = 1;
      end
      if (part_h.size() == H && part_y.size() == Y) begin
        foreach (part_h[i]) q_h.push_back(part_h[i]);
        foreach (part_y[i]) q_y.push_back(part_y[i]);
        q_ready.push_back(c + 1);
        part_h.delete(); part_y.delete();
      end
      if (!m_act && q_ready.size() > 0 && q_ready[0] <= c) begin
        m_act = 1; m_dec = 0; m_got = 0; m_s = c + 1; m_w0 = c + 2 + H + Y;
      end
    end
    e_start = m_act && cn == m_s;
    e_hv = m_act && cn >= m_s + 1 && cn <= m_s + H;
    e_yv = m_act && cn >= m_s + H + 1 && cn <= m_s + H + Y;
    {e_hr, e_hi} = '0;
    {e_yr, e_yi} = '0;
    if (e_hv) begin j = cn - m_s - 1; {e_hr, e_hi} = q_h[j]; end
    if (e_yv) begin j = cn - m_s - H - 1; {e_yr, e_yi} = q_y[j]; end
    e_rv = m_act && m_dec && m_got && cn == m_d + 1;
    e_busy = m_act;
  endtask

  task automatic compare();
    check("dec_start", dec_start, e_start);
    check("dec_h_valid", dec_h_valid, e_hv);
    check("dec_h_data", {dec_h_r, dec_h_i}, {e_hr, e_hi});
    check("dec_y_valid", dec_y_valid, e_yv);
    check("dec_y_data", {dec_y_r, dec_y_i}, {e_yr, e_yi});
    check("result_valid", result_valid, e_rv);
    check("result_sym", result_sym, m_rsym);
    check("frame_count", frame_count, m_fc);
    check("overflow", overflow, m_ovf);
    check("timeout_err", timeout_err, m_terr);
    check("busy", busy, e_busy);
    if (dec_start === 1'b1) mon_start = cyc;
    if (dec_h_valid === 1'b1) begin if (mon_fh < 0) mon_fh = cyc; mon_lh = cyc; end
    if (dec_y_valid === 1'b1) begin if (mon_fy < 0) mon_fy = cyc; mon_ly = cyc; end
    if (result_valid === 1'b1) begin mon_rv++; mon_rv_cyc = cyc; end
  endtask

  // model step at each rising edge, comparison at each falling edge
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      compare();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_reset();
    mon_start = -1; mon_fh = -1; mon_lh = -1; mon_fy = -1; mon_ly = -1;
    mon_rv = 0; mon_rv_cyc = -1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    check("wait_idle_budget", busy, 1'b0);
  endtask

  // Load one frame; returns the cycle of the last accepted input word.
  task automatic load_frame(input bit interleave, output int k);
    if (interleave) begin
      for (int i = 0; i < H; i++) begin
        in_h_valid = 1; in_h_r = $urandom(); in_h_i = $urandom();
        in_y_valid = 1; in_y_r = $urandom(); in_y_i = $urandom();
        k = cyc;
        tick();
      end
    end else begin
      for (int i = 0; i < H; i++) begin
        in_h_valid = 1; in_h_r = $urandom(); in_h_i = $urandom();
        k = cyc;
        tick();
      end
      in_h_valid = 0;
      for (int i = 0; i < Y; i++) begin
        in_y_valid = 1; in_y_r = $urandom(); in_y_i = $urandom();
        k = cyc;
        tick();
      end
    end
    in_h_valid = 0; in_y_valid = 0;
    in_h_r = '0; in_h_i = '0; in_y_r = '0; in_y_i = '0;
  endtask

  task automatic pulse_done(input logic [11:0] s);
    dec_done = 1; dec_sym = s;
    tick();
    dec_done = 0; dec_sym = '0;
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1;
    repeat (n) tick();
    sys_rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, d;
    sys_rst = 1; in_h_valid = 0; in_y_valid = 0; dec_done = 0; dec_sym = '0;
    in_h_r = '0; in_h_i = '0; in_y_r = '0; in_y_i = '0;
    mon_reset();
    do_reset(3);
    check("rst_result_sym", result_sym, 12'h000);
    check("rst_frame_count", frame_count, 16'h0000);
    check("rst_overflow", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);

    // single frame: H burst then Y burst, done 8 cycles into WAIT
    mon_reset();
    load_frame(0, k);
    wait_until(k + 18);
    pulse_done(12'hA5C);
    wait_idle(50);
    check("single_start_cyc", mon_start, k + 2);
    check("single_first_h", mon_fh, k + 3);
    check("single_last_h", mon_lh, k + 6);
    check("single_first_y", mon_fy, k + 7);
    check("single_last_y", mon_ly, k + 10);
    check("single_rv_cyc", mon_rv_cyc, k + 19);
    check("single_rv_count", mon_rv, 1);
    check("single_result_sym", result_sym, 12'hA5C);
    check("single_frame_count", frame_count, 16'd1);

    // interleaved fill
    mon_reset();
    load_frame(1, k);
    wait_until(k + 11);
    pulse_done(12'h123);
    wait_idle(50);
    check("inter_start_cyc", mon_start, k + 2);
    check("inter_overflow", overflow, 1'b0);
    check("inter_frame_count", frame_count, 16'd2);

    // ping-pong: B loads during A's WAIT, C is dropped while both banks are full
    load_frame(0, k);
    wait_until(k + 11);
    load_frame(1, d);
    load_frame(1, d);
    check("pp_overflow", overflow, 1'b1);
    mon_reset();
    d = cyc;
    pulse_done(12'h456);
    wait_until(d + 2 + H + Y + 3);
    check("pp_next_start", mon_start, d + 2);
    pulse_done(12'h789);
    wait_idle(50);
    check("pp_frame_count", frame_count, 16'd4);
    check("pp_result_sym", result_sym, 12'h789);

`ifdef SCHED_TIMEOUT_EN
    // watchdog: done exactly on the expiry cycle wins
    do_reset(1);
    mon_reset();
    load_frame(0, k);
    wait_until(k + 11 + TO - 1);
    pulse_done(12'h3C1);
    wait_idle(50);
    check("wd_edge_terr", timeout_err, 1'b0);
    check("wd_edge_sym", result_sym, 12'h3C1);
    check("wd_edge_rv", mon_rv, 1);
    // watchdog: no done at all
    mon_reset();
    load_frame(0, k);
    wait_until(k + 3);
    wait_idle(60);
    check("wd_terr", timeout_err, 1'b1);
    check("wd_no_rv", mon_rv, 0);
    check("wd_frame_count", frame_count, 16'd1);
    check("wd_release_cyc", cyc, k + 11 + TO + 1);
`endif

    // reset in the middle of the H burst
    load_frame(0, k);
    wait_until(k + 5);
    do_reset(1);
    check("mid_rst_hv", dec_h_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_fc", frame_count, 16'd0);
    check("mid_rst_rv", result_valid, 1'b0);
    mon_reset();
    load_frame(0, k);
    wait_until(k + 13);
    pulse_done(12'h0F0);
    wait_idle(50);
    check("after_rst_fc", frame_count, 16'd1);
    check("after_rst_rv", mon_rv, 1);

    // stray dec_done while idle
    mon_reset();
    pulse_done(12'hFFF);
    repeat (3) tick();
    check("stray_fc", frame_count, 16'd1);
    check("stray_rv", mon_rv, 0);
    check("stray_sym", result_sym, 12'h0F0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_h_valid = ($urandom_range(0, 2) == 0);
      in_h_r = $urandom(); in_h_i = $urandom();
      in_y_valid = ($urandom_range(0, 2) == 0);
      in_y_r = $urandom(); in_y_i = $urandom();
      dec_done = ($urandom_range(0, 11) == 0);
      dec_sym = 12'($urandom_range(0, 4095));
      sys_rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    in_h_valid = 0; in_y_valid = 0; sys_rst = 0;
    for (int i = 0; i < 200; i++) begin
      dec_done = ($urandom_range(0, 3) == 0);
      dec_sym = 12'($urandom_range(0, 4095));
      tick();
    end
    dec_done = 0;
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // run-time bound
  initial begin
    #1000000;
    bad++;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soml_frame_scheduler.md
# soml_frame_scheduler

Frame-level sequencer between the UART-side sample source and `soml_decoder_top`. It collects H and Y words into a two-bank ping-pong frame store, then drives the decoder through one frame: start pulse, H burst, Y burst, and wait for `output_valid`. It captures the 12-bit result and reports frame count, overflow and watchdog status. While one frame is being decoded, the next frame can be loaded into the other bank.

## Interface
- `H_WORDS`, default 4: complex H words per frame.
- `Y_WORDS`, default 4: complex Y words per frame.
- `TIMEOUT`, default 1023: maximum cycles in WAIT before the frame is abandoned.
- `W`, default 32: width of each real/imag component.
- `clk`  in  1  single clock; all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `in_h_r`, `in_h_i`  in  W  H sample from the source.
- `in_h_valid`  in  1  H sample strobe, one word per high cycle.
- `in_y_r`, `in_y_i`  in  W  Y sample from the source.
- `in_y_valid`  in  1  Y sample strobe.
- `dec_start`  out  1  one-cycle start pulse to the decoder.
- `dec_h_r`, `dec_h_i`  out  W  H word to the decoder.
- `dec_h_valid`  out  1  H word strobe.
- `dec_y_r`, `dec_y_i`  out  W  Y word to the decoder.
- `dec_y_valid`  out  1  Y word strobe.
- `dec_done`  in  1  decoder `output_valid`.
- `dec_sym`  in  12  decoder `signal_out_12bit`.
- `result_valid`  out  1  one-cycle pulse when `result_sym` updates.
- `result_sym`  out  12  last captured decoded symbol.
- `frame_count`  out  16  completed frames; wraps at 16 bits.
- `overflow`  out  1  sticky; an input word was dropped.
- `timeout_err`  out  1  sticky; a frame was abandoned by the watchdog.
- `busy`  out  1  dispatch FSM is not in IDLE.

## Operation
**Reset.** All outputs are 0 and both banks are empty. Fill pointer = bank 0, dispatch pointer = bank 0, FSM = IDLE.

**Fill side.**
- The H and Y counters are independent. `in_h_valid` and `in_y_valid` may both be high in the same cycle; both words are written.
- The bank is complete when the H count equals `H_WORDS` and the Y count equals `Y_WORDS`. On the cycle after the completing write:
  - the bank is marked full;
  - the counters clear;
  - the fill pointer toggles.
- A word is dropped and `overflow` is set when either of these holds:
  - the fill bank is still full (not yet released);
  - that word type's counter is already at its limit.

**Dispatch FSM.** States are IDLE, START, SEND_H, SEND_Y, WAIT, RELEASE.
- IDLE → START when the dispatch bank is full.
- START: `dec_start` = 1 for one cycle. Then SEND_H.
- SEND_H: `H_WORDS` consecutive cycles with `dec_h_valid` = 1. Words are sent in index order 0..`H_WORDS`-1. Then SEND_Y.
- SEND_Y: `Y_WORDS` cycles with `dec_y_valid` = 1, same ordering. Then WAIT.
- WAIT:
  - on `dec_done`, set `result_sym` = `dec_sym`, pulse `result_valid`, increment `frame_count`, then go to RELEASE;
  - on watchdog expiry, set `timeout_err` and go to RELEASE with no `result_valid`.
- RELEASE: clear the full flag of the dispatch bank, toggle the dispatch pointer, then IDLE.
- `dec_done` in any state other than WAIT is ignored.
- `dec_*_r/i` are 0 whenever the matching valid is low.

## Timing
- Cycle numbering: the bank becomes full at cycle t.
  - START at t+1.
  - H words at t+2 .. t+1+`H_WORDS`.
  - Y words at the following `Y_WORDS` cycles.
  - WAIT begins the cycle after the last Y word.
- `result_valid` is registered: it goes high the cycle after `dec_done` is sampled in WAIT.
- RELEASE lasts one cycle. With the other bank already full, the next START occurs 2 cycles after the decision cycle in WAIT.
- The watchdog counter clears on WAIT entry and increments each WAIT cycle. Expiry is when the count reaches `TIMEOUT`.
- If `dec_done` arrives in the same cycle as expiry, `dec_done` wins and `timeout_err` is not set.
- A release and a fill write to the same bank in the same cycle: the release takes effect first, so the write is accepted.
- `frame_count` wraps from 0xFFFF to 0x0000 with no flag.
- Asserting `sys_rst` mid-frame aborts everything. The next cycle shows the full reset state, including valids = 0, and no `result_valid` is generated.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - the watchdog is present;
  - `TIMEOUT` is honoured;
  - `timeout_err` behaves as described.
- `SCHED_TIMEOUT_EN` undefined:
  - no watchdog counter;
  - WAIT exits only on `dec_done` (or reset);
  - `timeout_err` is tied to 0.

## Test plan
- Single frame: 4 H then 4 Y words, `dec_done` with `dec_sym`=0xA5C eight cycles into WAIT → `dec_start` at t+1; H valids t+2..t+5; Y valids t+6..t+9; `result_sym`=0xA5C; one `result_valid` pulse; `frame_count`=1.
- Interleaved fill: H and Y valid together for 4 cycles → bank complete after 4 cycles; words dispatched in index order; `overflow`=0.
- Ping-pong: load frame B during WAIT of frame A → frame B START 2 cycles after A's `dec_done` is sampled; then loading a third frame while both banks are full → `overflow`=1 and words are dropped.
- Watchdog (macro on, `TIMEOUT`=16): no `dec_done` → `timeout_err`=1 after 16 WAIT cycles; no `result_valid`; bank released. Variant: `dec_done` exactly on the expiry cycle → result captured and `timeout_err`=0.
- Reset mid-SEND_H (after 2 H words) → next cycle all outputs 0 and FSM IDLE; a fresh full frame then decodes normally with `frame_count`=1.
- Stray `dec_done` while IDLE → ignored; `result_valid` stays 0 and `frame_count` is unchanged.
